// File: rtl/free_list_alloc_arbiter_pkg.sv
// Shared constants and helpers for the free-list allocation controller.
package free_list_alloc_arbiter_pkg;

  localparam int NUM_PHYS_REGS_DEF = 64;
  localparam int NUM_REQ_DEF       = 4;

  // Register 0 is hard-wired and never handed out, so it never sits in the list.
  localparam int RESERVED_REG = 0;
  localparam int NUM_RESERVED = 1;

  // Source feeding the single free-list enqueue port this cycle.
  typedef enum logic [1:0] {
    ENQ_NONE   = 2'd0,
    ENQ_RETIRE = 2'd1,
    ENQ_RETURN = 2'd2
  } enq_src_e;

  function automatic int log_phys(input int n);
    return $clog2(n);
  endfunction

  // A single requester still needs a one-bit index.
  function automatic int log_req(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/free_list_alloc_arbiter_if.sv
// Rename-side and free-list-side signals of the allocation controller.
interface free_list_alloc_arbiter_if #(
  parameter int NUM_PHYS_REGS = free_list_alloc_arbiter_pkg::NUM_PHYS_REGS_DEF,
  parameter int NUM_REQ       = free_list_alloc_arbiter_pkg::NUM_REQ_DEF
);
  localparam int LOG_PHYS = free_list_alloc_arbiter_pkg::log_phys(NUM_PHYS_REGS);

  logic [NUM_REQ-1:0]  Req_IN;
  logic [NUM_REQ-1:0]  Grant_OUT;
  logic [LOG_PHYS-1:0] PhysReg_OUT;
  logic                Retire_IN;
  logic [LOG_PHYS-1:0] RetireReg_IN;
  logic                Flush_IN;
  logic                FL_Enqueue_OUT;
  logic [LOG_PHYS-1:0] FL_Data_OUT;
  logic                FL_Dequeue_OUT;
  logic                FL_DequeueResult_IN;
  logic [LOG_PHYS-1:0] FL_Data_IN;
  logic [LOG_PHYS:0]   FreeCount_OUT;
  logic                Error_OUT;

  // Controller side.
  modport slave (
    input  Req_IN, Retire_IN, RetireReg_IN, Flush_IN, FL_DequeueResult_IN, FL_Data_IN,
    output Grant_OUT, PhysReg_OUT, FL_Enqueue_OUT, FL_Data_OUT, FL_Dequeue_OUT,
           FreeCount_OUT, Error_OUT
  );

  // Environment side (rename slots plus free list).
  modport master (
    output Req_IN, Retire_IN, RetireReg_IN, Flush_IN, FL_DequeueResult_IN, FL_Data_IN,
    input  Grant_OUT, PhysReg_OUT, FL_Enqueue_OUT, FL_Data_OUT, FL_Dequeue_OUT,
           FreeCount_OUT, Error_OUT
  );

endinterface

// File: rtl/free_list_alloc_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module free_list_alloc_arbiter_rr_arbiter
  import free_list_alloc_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int LOG_REQ = log_req(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LOG_REQ-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [LOG_REQ-1:0] idx
);

  logic found;
  int   slot;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        idx         = LOG_REQ'(slot);
      end
    end
  end

endmodule

// File: rtl/free_list_alloc_arbiter.sv
// Shares the free list's dequeue port among rename requesters and its enqueue
// port between commit frees and flush returns, while tracking the free count.
module free_list_alloc_arbiter
  import free_list_alloc_arbiter_pkg::*;
#(
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  parameter int NUM_REQ       = NUM_REQ_DEF
) (
  input logic                      CLK,
  input logic                      RESET,
  free_list_alloc_arbiter_if.slave io
);

  localparam int LOG_PHYS = log_phys(NUM_PHYS_REGS);
  localparam int LOG_REQ  = log_req(NUM_REQ);
  localparam int CW       = LOG_PHYS + 1;
  localparam logic [CW-1:0]      COUNT_MAX = CW'(NUM_PHYS_REGS);
  localparam logic [CW-1:0]      COUNT_RST = CW'(NUM_PHYS_REGS - NUM_RESERVED);
  localparam logic [LOG_REQ-1:0] LAST_REQ  = LOG_REQ'(NUM_REQ - 1);

  logic [LOG_REQ-1:0]  rr_ptr;
  logic                pend_valid;
  logic [LOG_REQ-1:0]  pend_id;
  logic                return_valid;
  logic [LOG_PHYS-1:0] return_reg;
  logic [CW-1:0]       free_count;
  logic                error;

  logic [NUM_REQ-1:0]  pend_mask;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [LOG_REQ-1:0]  win_idx;
  logic                win_any;
  enq_src_e            enq_src;
  logic [LOG_PHYS-1:0] enq_data;
  logic                enq;
  logic                issue;
  logic                resp_ok;
  logic                grant_fire;
  logic [CW:0]         count_sum;
  logic                saturate;
  logic [CW-1:0]       count_next;

  // One-hot of the requester whose dequeue result arrives this cycle.
  always_comb begin
    pend_mask = '0;
    if (pend_valid) pend_mask[pend_id] = 1'b1;
  end

  // A requester already waiting on a result must not be issued twice.
  assign eligible = io.Req_IN & ~pend_mask;

  free_list_alloc_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .idx   (win_idx)
  );

  assign win_any = |win_onehot;

  // Commit frees take the enqueue port ahead of a pending flush return.
  always_comb begin
    enq_src  = ENQ_NONE;
    enq_data = '0;
    if (!RESET) begin
      if (io.Retire_IN) begin
        enq_src  = ENQ_RETIRE;
        enq_data = io.RetireReg_IN;
      end else if (return_valid) begin
        enq_src  = ENQ_RETURN;
        enq_data = return_reg;
      end
    end
  end

  assign enq = (enq_src != ENQ_NONE);

  // The list enqueues before it dequeues, so a same-cycle free makes an empty list safe.
  assign issue = !RESET && win_any && !io.Flush_IN && !return_valid &&
                 ((free_count != '0) || enq);

  assign resp_ok    = pend_valid && io.FL_DequeueResult_IN;
  assign grant_fire = !RESET && resp_ok && !io.Flush_IN;

  // Free count moves with the list ports; exceeding the physical total is a bookkeeping fault.
  always_comb begin
    count_sum  = {1'b0, free_count} + (CW+1)'(enq) - (CW+1)'(issue);
    saturate   = (count_sum > {1'b0, COUNT_MAX});
    count_next = saturate ? COUNT_MAX : count_sum[CW-1:0];
  end

  assign io.Grant_OUT      = grant_fire ? pend_mask : '0;
  assign io.PhysReg_OUT    = grant_fire ? io.FL_Data_IN : '0;
  assign io.FL_Enqueue_OUT = enq;
  assign io.FL_Data_OUT    = enq_data;
  assign io.FL_Dequeue_OUT = issue;
  assign io.FreeCount_OUT  = RESET ? COUNT_RST : free_count;
  assign io.Error_OUT      = RESET ? 1'b0 : error;

  // Pointer, in-flight allocation, flush return slot, free count and sticky error.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr       <= '0;
      pend_valid   <= 1'b0;
      pend_id      <= '0;
      return_valid <= 1'b0;
      return_reg   <= '0;
      free_count   <= COUNT_RST;
      error        <= 1'b0;
    end else begin
      if (issue) begin
        pend_valid <= 1'b1;
        pend_id    <= win_idx;
        rr_ptr     <= (win_idx == LAST_REQ) ? '0 : win_idx + LOG_REQ'(1);
      end else begin
        pend_valid <= 1'b0;
      end

      // A squashed allocation still owns a register; park it for re-enqueue.
      if (resp_ok && io.Flush_IN) begin
        return_valid <= 1'b1;
        return_reg   <= io.FL_Data_IN;
      end else if (enq_src == ENQ_RETURN) begin
        return_valid <= 1'b0;
      end

      free_count <= count_next;

      if ((pend_valid && !io.FL_DequeueResult_IN) || saturate) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list_alloc_arbiter.sv
// Bench for free_list_alloc_arbiter: behavioural free list, reference model and grant scoreboard.
module tb_free_list_alloc_arbiter;
  import free_list_alloc_arbiter_pkg::*;

  localparam int NP = 64;
  localparam int NR = 4;
  localparam int LP = 6;

  logic CLK   = 1'b1;
  logic RESET = 1'b1;

  free_list_alloc_arbiter_if #(.NUM_PHYS_REGS(NP), .NUM_REQ(NR)) bus ();

  free_list_alloc_arbiter #(.NUM_PHYS_REGS(NP), .NUM_REQ(NR)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .io    (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural free list (environment) ----------------
  int   fl_q[$];
  logic force_fail = 1'b0;
  logic env_res = 1'b0;
  logic [LP-1:0] env_data = '0;
  logic e_enq, e_deq;
  int   e_data;

  assign bus.FL_DequeueResult_IN = env_res;
  assign bus.FL_Data_IN          = env_data;

  always @(negedge CLK) begin
    #3;
    e_enq  = bus.FL_Enqueue_OUT;
    e_deq  = bus.FL_Dequeue_OUT;
    e_data = int'(bus.FL_Data_OUT);
  end

  always @(posedge CLK) begin
    int v;
    if (RESET) begin
      fl_q.delete();
      for (int r = RESERVED_REG + 1; r < NP; r++) fl_q.push_back(r);
      env_res  <= 1'b0;
      env_data <= '0;
    end else begin
      if (e_enq) fl_q.push_back(e_data);
      if (e_deq && !force_fail && fl_q.size() > 0) begin
        v = fl_q.pop_front();
        env_res  <= 1'b1;
        env_data <= LP'(v);
      end else begin
        env_res  <= 1'b0;
        env_data <= '0;
      end
    end
  end

  // ---------------- reference model + scoreboard producer ----------------
  typedef struct { int id; int rg; int at; } exp_t;
  exp_t sb[$];

  int m_rr, m_pend, m_pend_reg, m_ret, m_cnt;
  bit m_pend_fail, m_err;
  int m_list[$];

  task automatic model_reset();
    m_rr = 0; m_pend = -1; m_pend_reg = 0; m_ret = -1; m_cnt = NP - 1;
    m_pend_fail = 0; m_err = 0;
    m_list.delete();
    for (int r = RESERVED_REG + 1; r < NP; r++) m_list.push_back(r);
    sb.delete();
  endtask

  always @(negedge CLK) begin
    int  enq_reg, win, new_ret;
    bit  exp_deq;
    if (RESET) begin
      check("rst_grant",  int'(bus.Grant_OUT), 0);
      check("rst_phys",   int'(bus.PhysReg_OUT), 0);
      check("rst_deq",    int'(bus.FL_Dequeue_OUT), 0);
      check("rst_enq",    int'(bus.FL_Enqueue_OUT), 0);
      check("rst_fldata", int'(bus.FL_Data_OUT), 0);
      check("rst_count",  int'(bus.FreeCount_OUT), NP - 1);
      check("rst_error",  int'(bus.Error_OUT), 0);
      model_reset();
    end else begin
      enq_reg = bus.Retire_IN ? int'(bus.RetireReg_IN) : m_ret;
      win = -1;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (win < 0 && bus.Req_IN[i] && i != m_pend) win = i;
      end
      exp_deq = (win >= 0) && !bus.Flush_IN && (m_ret < 0) && (m_cnt > 0 || enq_reg >= 0);

      check("dequeue",    int'(bus.FL_Dequeue_OUT), int'(exp_deq));
      check("enqueue",    int'(bus.FL_Enqueue_OUT), int'(enq_reg >= 0));
      if (enq_reg >= 0) check("enq_data", int'(bus.FL_Data_OUT), enq_reg);
      check("free_count", int'(bus.FreeCount_OUT), m_cnt);
      check("error",      int'(bus.Error_OUT), int'(m_err));
      if (bus.Flush_IN) check("grant_in_flush", int'(bus.Grant_OUT), 0);

      new_ret = (m_ret >= 0 && !bus.Retire_IN) ? -1 : m_ret;
      if (m_pend >= 0) begin
        if (m_pend_fail) m_err = 1;
        else if (bus.Flush_IN) begin
          new_ret = m_pend_reg;
          if (sb.size() > 0 && sb[$].at == cyc) void'(sb.pop_back());
        end
      end

      if (enq_reg >= 0) m_list.push_back(enq_reg);
      m_cnt = m_cnt + int'(enq_reg >= 0) - int'(exp_deq);
      if (m_cnt > NP) begin m_cnt = NP; m_err = 1; end

      if (exp_deq) begin
        m_pend = win;
        m_rr = (win + 1) % NR;
        m_pend_fail = force_fail || (m_list.size() == 0);
        if (!m_pend_fail) begin
          m_pend_reg = m_list.pop_front();
          sb.push_back('{win, m_pend_reg, cyc + 1});
        end
      end else begin
        m_pend = -1;
      end
      m_ret = new_ret;
    end
  end

  // ---------------- monitor: consumes expected grants ----------------
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (bus.Grant_OUT != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", int'(bus.Grant_OUT), 0);
      end else begin
        e = sb.pop_front();
        check("grant_onehot", int'(bus.Grant_OUT), 1 << e.id);
        check("grant_reg",    int'(bus.PhysReg_OUT), e.rg);
        check("grant_cycle",  cyc, e.at);
      end
    end else if (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check("missing_grant", 0, 1 << e.id);
    end
  end

  // ---------------- stimulus ----------------
  logic [NR-1:0] s_grant;
  int s_phys, s_deq, s_enq, s_data, s_cnt, s_err;

  task automatic tick(input logic [NR-1:0] r, input logic rt, input int rreg, input logic fl);
    bus.Req_IN       = r;
    bus.Retire_IN    = rt;
    bus.RetireReg_IN = LP'(rreg);
    bus.Flush_IN     = fl;
    @(negedge CLK); #2;
    s_grant = bus.Grant_OUT;
    s_phys  = int'(bus.PhysReg_OUT);
    s_deq   = int'(bus.FL_Dequeue_OUT);
    s_enq   = int'(bus.FL_Enqueue_OUT);
    s_data  = int'(bus.FL_Data_OUT);
    s_cnt   = int'(bus.FreeCount_OUT);
    s_err   = int'(bus.Error_OUT);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick('0, 0, 0, 0);
    tick('0, 0, 0, 0);
    RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] rq;
    int pool[$];
    int k, idx, rreg;
    logic rt, fl;

    bus.Req_IN = '0; bus.Retire_IN = 0; bus.RetireReg_IN = '0; bus.Flush_IN = 0;

    // single requester, first allocation
    do_reset();
    tick(4'b0001, 0, 0, 0);
    check("first_issue", s_deq, 1);
    tick(4'b0001, 0, 0, 0);
    check("first_grant", int'(s_grant), 1);
    check("first_reg", s_phys, 1);
    check("first_count", s_cnt, 62);
    tick('0, 0, 0, 0);

    // all requesters held: round-robin, one grant per cycle
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(4'b1111, 0, 0, 0);
      if (i > 0) begin
        check("rr_grant", int'(s_grant), 1 << ((i - 1) % NR));
        check("rr_reg", s_phys, i);
      end
    end
    tick('0, 0, 0, 0);

    // drain to empty, then allocate through a same-cycle retire
    do_reset();
    k = 0;
    do begin tick(4'b1111, 0, 0, 0); k++; end while (s_cnt != 0 && k < 80);
    check("drain_reached", s_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0001, 0, 0, 0);
      check("empty_no_deq", s_deq, 0);
    end
    tick(4'b0001, 1, 5, 0);
    check("retire_bypass_issue", s_deq, 1);
    tick(4'b0001, 0, 0, 0);
    check("retire_bypass_grant", int'(s_grant), 1);
    check("retire_bypass_reg", s_phys, 5);
    tick('0, 0, 0, 0);

    // flush in the response cycle returns the register
    do_reset();
    tick(4'b0001, 0, 0, 0);
    tick(4'b0001, 0, 0, 1);
    check("flush_no_grant", int'(s_grant), 0);
    tick(4'b0001, 0, 0, 0);
    check("flush_ret_enq", s_enq, 1);
    check("flush_ret_reg", s_data, 1);
    check("flush_ret_stall", s_deq, 0);
    tick(4'b0001, 0, 0, 0);
    check("flush_count_restored", s_cnt, 63);
    check("flush_reissue", s_deq, 1);
    tick(4'b0001, 0, 0, 0);
    check("flush_next_reg", s_phys, 2);
    tick('0, 0, 0, 0);

    // flush return colliding with a retire
    do_reset();
    tick(4'b0001, 0, 0, 0);
    tick(4'b0001, 0, 0, 0);
    tick(4'b0010, 0, 0, 0);
    tick(4'b0010, 0, 0, 1);
    tick(4'b0010, 1, 1, 0);
    check("collide_retire_first", s_data, 1);
    check("collide_stall1", s_deq, 0);
    tick(4'b0010, 0, 0, 0);
    check("collide_return_next", s_data, 2);
    check("collide_stall2", s_deq, 0);
    tick(4'b0010, 0, 0, 0);
    check("collide_resume", s_deq, 1);
    tick(4'b0010, 0, 0, 0);
    check("collide_grant", int'(s_grant), 2);
    check("collide_reg", s_phys, 3);
    tick('0, 0, 0, 0);

    // failed dequeue: no grant, sticky error until reset
    do_reset();
    force_fail = 1'b1;
    tick(4'b0001, 0, 0, 0);
    tick(4'b0001, 0, 0, 0);
    check("fail_no_grant", int'(s_grant), 0);
    force_fail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick('0, 0, 0, 0);
      check("error_sticky", s_err, 1);
    end
    do_reset();
    tick('0, 0, 0, 0);
    check("error_cleared", s_err, 0);

    // count saturation
    do_reset();
    tick('0, 1, 7, 0);
    tick('0, 1, 8, 0);
    tick('0, 0, 0, 0);
    check("sat_count", s_cnt, NP);
    check("sat_error", s_err, 1);

    // randomized traffic with a reset in the middle
    do_reset();
    rq = '0;
    for (int c = 0; c < 1500; c++) begin
      if (s_grant != '0) pool.push_back(s_phys);
      for (int i = 0; i < NR; i++) begin
        if (s_grant[i]) rq[i] = 1'($urandom_range(0, 1));
        else if (!rq[i]) rq[i] = ($urandom_range(0, 9) < 4);
      end
      rt = 0; rreg = 0;
      if (c == 700) begin
        RESET = 1'b1;
        pool.delete();
        rq = '0;
      end else begin
        RESET = 1'b0;
        if (pool.size() > 0 && $urandom_range(0, 3) == 0) begin
          idx  = $urandom_range(0, pool.size() - 1);
          rreg = pool[idx];
          pool.delete(idx);
          rt = 1;
        end
      end
      fl = ($urandom_range(0, 19) == 0);
      tick(rq, rt, rreg, fl);
    end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) tick('0, 0, 0, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
